impartitor_secvential: RTL and testbench

//  Sequential restoring divider, the inverse datapath of the shift-and-add

---
 rtl/impartitor_secvential.sv | 147 ++++++++++++++
 tb/tb_impartitor_secvential.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/impartitor_secvential.sv
// Sequential restoring divider: splits a 2*width-bit dividend by a width-bit
// divisor and produces one quotient bit per clock. The control unit starts it
// with load, waits while busy is high and reads the result when ready is high.
//
// Handshake: load is sampled only in IDLE or DONE. An accepted load drops
// ready, and the operands are checked in the cycle after the load edge.
// busy is high exactly while iterating (RUN). ready is high exactly in DONE,
// and quot/rem/div_zero/ovf are valid while ready is high. Loads seen in
// CHECK or RUN are ignored.
module impartitor_secvential #(
  parameter int width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [2*width-1:0]   OpA,
  input  logic [width-1:0]     OpB,
  output logic [width-1:0]     quot,
  output logic [width-1:0]     rem,
  output logic                 busy,
  output logic                 ready,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

  // CHECK is the cycle after load is accepted. In this cycle the captured
  // operands are classified as an error, which goes to DONE, or as a normal
  // division, which goes to RUN.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [2*width-1:0]   a, a_nx;          // captured dividend
  logic [width-1:0]     d, d_nx;          // captured divisor
  logic [width:0]       r, r_nx;          // partial remainder, one guard bit
  logic [width-1:0]     q, q_nx;          // dividend low half / quotient bits
  logic [CW-1:0]        cnt, cnt_nx;      // completed restoring steps
  logic [width-1:0]     quot_nx, rem_nx;
  logic                 dz_nx, ovf_nx;
  logic [width:0]       r_sh;
  logic [width:0]       d_ext;

  // Next-state and datapath update. Every register holds by default.
  always_comb begin
    state_nx = state;
    a_nx     = a;
    d_nx     = d;
    r_nx     = r;
    q_nx     = q;
    cnt_nx   = cnt;
    quot_nx  = quot;
    rem_nx   = rem;
    dz_nx    = div_zero;
    ovf_nx   = ovf;
    // Shift {R,Q} left by one bit. R is always below the divisor before the
    // shift, so r[width] is zero and no bit is lost.
    r_sh     = {r[width-1:0], q[width-1]};
    d_ext    = {1'b0, d};

    case (state)
      IDLE, DONE: begin
        if (load) begin
          a_nx     = OpA;
          d_nx     = OpB;
          dz_nx    = 1'b0;
          ovf_nx   = 1'b0;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (d == '0) begin
          quot_nx  = '1;
          rem_nx   = a[width-1:0];
          dz_nx    = 1'b1;
          state_nx = DONE;
        end else if (a[2*width-1:width] >= d) begin
          quot_nx  = '1;
          rem_nx   = '0;
          ovf_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          r_nx     = {1'b0, a[2*width-1:width]};
          q_nx     = a[width-1:0];
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (r_sh >= d_ext) begin
          r_nx = r_sh - d_ext;
          q_nx = {q[width-2:0], 1'b1};
        end else begin
          r_nx = r_sh;
          q_nx = {q[width-2:0], 1'b0};
        end
        cnt_nx = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          quot_nx  = q_nx;
          rem_nx   = r_nx[width-1:0];
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything and aborts any
  // division in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a        <= '0;
      d        <= '0;
      r        <= '0;
      q        <= '0;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nx;
      a        <= a_nx;
      d        <= d_nx;
      r        <= r_nx;
      q        <= q_nx;
      cnt      <= cnt_nx;
      quot     <= quot_nx;
      rem      <= rem_nx;
      div_zero <= dz_nx;
      ovf      <= ovf_nx;
    end
  end

  // Status decoded from the state register, so busy and ready are mutually
  // exclusive and free of glitches.
  assign busy  = (state == RUN);
  assign ready = (state == DONE);

endmodule

// File: tb/tb_impartitor_secvential.sv
// Bench for impartitor_secvential. Directed operands with hand-computed
// results. A monitor scores every rising edge of ready against the
// expected queue. The driver checks latency and the number of busy cycles.
module tb_impartitor_secvential;

  localparam int W  = 8;
  localparam int EW = 2 * W + 2;   // {quot, rem, div_zero, ovf}

  logic              clk;
  logic              reset;
  logic              load;
  logic [2*W-1:0]    OpA;
  logic [W-1:0]      OpB;
  logic [W-1:0]      quot;
  logic [W-1:0]      rem;
  logic              busy;
  logic              ready;
  logic              div_zero;
  logic              ovf;

  logic [EW-1:0]     exp_q[$];
  int                errors = 0;
  int                checks = 0;
  logic              ready_prev = 1'b0;

  impartitor_secvential #(.width(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .OpA      (OpA),
    .OpB      (OpB),
    .quot     (quot),
    .rem      (rem),
    .busy     (busy),
    .ready    (ready),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: each new result is compared with the head of the expected queue
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got quot=%0d rem=%0d dz=%0b ovf=%0b, none expected",
                 quot, rem, div_zero, ovf);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({quot, rem, div_zero, ovf} !== e) begin
          errors++;
          $display("FAIL result: got quot=%0d rem=%0d dz=%0b ovf=%0b, expected quot=%0d rem=%0d dz=%0b ovf=%0b",
                   quot, rem, div_zero, ovf, e[EW-1:W+2], e[W+1:2], e[1], e[0]);
        end
      end
    end
    if (busy && ready) begin
      checks++;
      errors++;
      $display("FAIL busy_ready_overlap: busy=1 ready=1, required not both high");
    end
    ready_prev = ready;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One division. The expected result is queued for the monitor, and the
  // ready latency and busy count are checked here. If inj > 0, a second load
  // with operands a2/b2 is pulsed k=inj cycles after the load edge.
  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eov,
                        input int inj, input logic [2*W-1:0] a2, input logic [W-1:0] b2);
    int k;
    int nb;
    bit err;
    err = edz | eov;
    exp_q.push_back({eq, er, edz, eov});
    @(negedge clk);
    load = 1'b1;
    OpA  = a;
    OpB  = b;
    @(negedge clk);              // edge N has passed
    load = 1'b0;
    k  = 0;
    nb = 0;
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
      if (inj > 0 && k == inj) begin
        load = 1'b1;
        OpA  = a2;
        OpB  = b2;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    check("latency", k, err ? 1 : W + 1);
    check("busy_cycles", nb, err ? 0 : W);
  endtask

  // stimulus
  initial begin
    reset = 1'b1;
    load  = 1'b0;
    OpA   = '0;
    OpB   = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {quot, rem, busy, ready, div_zero, ovf}, '0);
    reset = 1'b0;

    // basic and boundary divisions
    run_op(16'd100,   8'd7,    8'd14,  8'd2,   1'b0, 1'b0, 0, '0, '0);
    run_op(16'd65025, 8'd255,  8'd255, 8'd0,   1'b0, 1'b0, 0, '0, '0);
    run_op(16'h1234,  8'd0,    8'hFF,  8'h34,  1'b1, 1'b0, 0, '0, '0);
    run_op(16'hFF00,  8'h10,   8'hFF,  8'd0,   1'b0, 1'b1, 0, '0, '0);
    run_op(16'd1000,  8'd33,   8'd30,  8'd10,  1'b0, 1'b0, 0, '0, '0);
    run_op(16'd65279, 8'd255,  8'd255, 8'd254, 1'b0, 1'b0, 0, '0, '0);
    run_op(16'h00FF,  8'd1,    8'd255, 8'd0,   1'b0, 1'b0, 0, '0, '0);
    run_op(16'h0100,  8'd1,    8'hFF,  8'd0,   1'b0, 1'b1, 0, '0, '0);
    run_op(16'd0,     8'd5,    8'd0,   8'd0,   1'b0, 1'b0, 0, '0, '0);

    // a load during RUN is ignored
    run_op(16'd100,   8'd7,    8'd14,  8'd2,   1'b0, 1'b0, 3, 16'd5000, 8'd3);

    // a reset during RUN aborts the division and clears the outputs
    @(negedge clk);
    load = 1'b1;
    OpA  = 16'd5000;
    OpB  = 8'd77;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    #1;
    check("reset_mid_run", {quot, rem, busy, ready, div_zero, ovf}, '0);
    @(negedge clk);
    reset = 1'b0;
    // 5000 = 77*64 + 72
    run_op(16'd5000,  8'd77,   8'd64,  8'd72,  1'b0, 1'b0, 0, '0, '0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
